stage4_mem: RTL and testbench

- Pipeline stage 4 (MEM) of the 5-stage LoongArch CPU.
- Accepts the EX-stage bus and registers it. Takes the synchronous data-SRAM read data for a load issued in EX and extracts/extends the addressed byte, halfword or word.
- Drives ms_to_ws_bus and ms_to_ws_valid into stage5_WB, and ms_to_ds_bus to the decode-stage forwarding logic.
- Honours ws_allow_in back-pressure. Holds SRAM read data across stalls.

---
 rtl/stage4_mem_pkg.sv | 25 ++
 rtl/stage4_mem_load_align.sv | 29 ++
 rtl/stage4_mem.sv | 78 +++++++
 tb/tb_stage4_mem.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/stage4_mem_pkg.sv
// Shared MEM-stage definitions: inter-stage bus widths, the EX->MEM bus layout
// and one-hot load-op bit positions.
package stage4_mem_pkg;

   localparam int WIDTH_ES_TO_MS_BUS = 76;
   localparam int WIDTH_MS_TO_WS_BUS = 70;
   localparam int WIDTH_MS_TO_DS_BUS = 38;

   localparam int LD_B  = 0;
   localparam int LD_BU = 1;
   localparam int LD_H  = 2;
   localparam int LD_HU = 3;
   localparam int LD_W  = 4;

   // Field order matches es_to_ms_bus bit positions, MSB first.
   typedef struct packed {
      logic [4:0]  ld_op;
      logic        res_from_mem;
      logic [31:0] alu_result;
      logic [4:0]  dest;
      logic        gr_we;
      logic [31:0] pc;
   } es_to_ms_t;

endpackage

// File: rtl/stage4_mem_load_align.sv
// Picks the addressed byte/halfword out of a 32-bit read word and extends it.
module mem_load_align
   import stage4_mem_pkg::*;
(
   input  logic [31:0] mem_rdata,
   input  logic [1:0]  addr,
   input  logic [4:0]  ld_op,
   output logic [31:0] load_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // addr[0] is ignored for halfwords; misaligned accesses trap further down.
   always_comb begin
      byte_sel  = mem_rdata[{addr, 3'b000} +: 8];
      half_sel  = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      load_data = mem_rdata;
      if (ld_op[LD_B])
         load_data = {{24{byte_sel[7]}}, byte_sel};
      else if (ld_op[LD_BU])
         load_data = {24'b0, byte_sel};
      else if (ld_op[LD_H])
         load_data = {{16{half_sel[15]}}, half_sel};
      else if (ld_op[LD_HU])
         load_data = {16'b0, half_sel};
   end

endmodule

// File: rtl/stage4_mem.sv
// Pipeline stage 4 (MEM): registers the EX bus, holds SRAM read data across
// WB stalls and produces the write-back result and forwarding bus.
module stage4_mem
   import stage4_mem_pkg::*;
(
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          es_to_ms_valid,
   output logic                          ms_allow_in,
   input  logic [WIDTH_ES_TO_MS_BUS-1:0] es_to_ms_bus,
   input  logic [31:0]                   data_sram_rdata,
   input  logic                          ws_allow_in,
   output logic                          ms_to_ws_valid,
   output logic [WIDTH_MS_TO_WS_BUS-1:0] ms_to_ws_bus,
   output logic [WIDTH_MS_TO_DS_BUS-1:0] ms_to_ds_bus
);

   logic        ms_valid_q, ms_valid_d;
   es_to_ms_t   bus_q, bus_d;
   logic [31:0] rd_buf_q, rd_buf_d;
   logic        rd_buf_v_q, rd_buf_v_d;

   logic        ms_ready_go, accept, leave;
   logic [31:0] mem_rdata, load_data, final_result;

   assign ms_ready_go    = 1'b1;
   assign ms_allow_in    = !ms_valid_q || (ms_ready_go && ws_allow_in);
   assign ms_to_ws_valid = ms_valid_q && ms_ready_go;
   assign accept         = es_to_ms_valid && ms_allow_in;
   assign leave          = ms_to_ws_valid && ws_allow_in;

   // SRAM data is only valid in the first MEM cycle, so a stalled load
   // snapshots it; an entering instruction invalidates the snapshot.
   always_comb begin
      ms_valid_d = ms_valid_q;
      bus_d      = bus_q;
      rd_buf_d   = rd_buf_q;
      rd_buf_v_d = rd_buf_v_q;
      if (ms_allow_in)
         ms_valid_d = es_to_ms_valid;
      if (accept) begin
         bus_d      = es_to_ms_bus;
         rd_buf_v_d = 1'b0;
      end else if (ms_valid_q && !rd_buf_v_q && !leave) begin
         rd_buf_d   = data_sram_rdata;
         rd_buf_v_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ms_valid_q <= 1'b0;
         bus_q      <= '0;
         rd_buf_q   <= '0;
         rd_buf_v_q <= 1'b0;
      end else begin
         ms_valid_q <= ms_valid_d;
         bus_q      <= bus_d;
         rd_buf_q   <= rd_buf_d;
         rd_buf_v_q <= rd_buf_v_d;
      end
   end

   assign mem_rdata = rd_buf_v_q ? rd_buf_q : data_sram_rdata;

   mem_load_align u_align (
      .mem_rdata (mem_rdata),
      .addr      (bus_q.alu_result[1:0]),
      .ld_op     (bus_q.ld_op),
      .load_data (load_data)
   );

   assign final_result = bus_q.res_from_mem ? load_data : bus_q.alu_result;

   assign ms_to_ws_bus = {final_result, bus_q.dest, bus_q.gr_we, bus_q.pc};
   assign ms_to_ds_bus = {bus_q.gr_we && ms_valid_q, bus_q.dest, final_result};

endmodule

// File: tb/tb_stage4_mem.sv
// Scoreboard bench for stage4_mem: a small sync-SRAM model feeds read data,
// expected WB results are queued on accept and compared on WB transfer.
module tb_stage4_mem;
   import stage4_mem_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        es_to_ms_valid;
   logic        ms_allow_in;
   logic [75:0] es_to_ms_bus;
   logic [31:0] data_sram_rdata;
   logic        ws_allow_in;
   logic        ms_to_ws_valid;
   logic [69:0] ms_to_ws_bus;
   logic [37:0] ms_to_ds_bus;

   always #5 clk = ~clk;

   stage4_mem dut (
      .clk             (clk),
      .reset           (reset),
      .es_to_ms_valid  (es_to_ms_valid),
      .ms_allow_in     (ms_allow_in),
      .es_to_ms_bus    (es_to_ms_bus),
      .data_sram_rdata (data_sram_rdata),
      .ws_allow_in     (ws_allow_in),
      .ms_to_ws_valid  (ms_to_ws_valid),
      .ms_to_ws_bus    (ms_to_ws_bus),
      .ms_to_ds_bus    (ms_to_ds_bus)
   );

   typedef struct {
      logic [31:0] pc;
      logic        we;
      logic [4:0]  dest;
      logic [31:0] res;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   logic burst_done;

   task automatic chk(string tag, logic [69:0] got, logic [69:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference load result, written as shift-and-truncate.
   function automatic logic [31:0] model(logic [31:0] alu, logic rfm, logic [4:0] op,
                                         logic [31:0] w);
      logic [31:0] sh;
      if (!rfm) return alu;
      if (op[0] || op[1]) begin
         sh = w >> (alu[1:0] * 8);
         return op[0] ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
      end
      if (op[2] || op[3]) begin
         sh = alu[1] ? (w >> 16) : w;
         return op[2] ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
      end
      return w;
   endfunction

   // Sync SRAM: returns the accepted instruction's data one edge later,
   // garbage otherwise so only a held copy can keep a stalled load correct.
   logic [31:0] cur_rdata;
   logic [31:0] rd_next;
   logic        acc_n = 1'b0;
   always @(negedge clk) begin
      acc_n   = es_to_ms_valid && ms_allow_in && !reset;
      rd_next = cur_rdata;
   end
   always @(posedge clk) data_sram_rdata <= acc_n ? rd_next : 32'hDEADBEEF;

   always @(negedge clk) begin : monitor
      exp_t e;
      if (!reset && ms_to_ws_valid && ws_allow_in) begin
         if (sb.size() == 0) begin
            chk("sb_underflow", 70'd1, 70'd0);
         end else begin
            e = sb.pop_front();
            chk("ws_pc",     {38'd0, ms_to_ws_bus[31:0]},  {38'd0, e.pc});
            chk("ws_we",     {69'd0, ms_to_ws_bus[32]},    {69'd0, e.we});
            chk("ws_dest",   {65'd0, ms_to_ws_bus[37:33]}, {65'd0, e.dest});
            chk("ws_result", {38'd0, ms_to_ws_bus[69:38]}, {38'd0, e.res});
            chk("ds_bus",    {32'd0, ms_to_ds_bus},        {32'd0, e.we, e.dest, e.res});
         end
      end
   end

   task automatic send(logic [31:0] pc, logic we, logic [4:0] dest, logic [31:0] alu,
                       logic rfm, logic [4:0] op, logic [31:0] rd);
      int t = 0;
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = {op, rfm, alu, dest, we, pc};
      cur_rdata      = rd;
      do begin
         @(negedge clk);
         t++;
      end while (!ms_allow_in && t < 40);
      if (!ms_allow_in) begin
         chk("accept_timeout", 70'd0, 70'd1);
         es_to_ms_valid = 1'b0;
         return;
      end
      sb.push_back('{pc, we, dest, model(alu, rfm, op, rd)});
      @(posedge clk); #1;
   endtask

   task automatic cycles(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0;
      ws_allow_in = 1'b1; cur_rdata = '0; burst_done = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_allow_in", {69'd0, ms_allow_in},    70'd1);
      chk("rst_ws_valid", {69'd0, ms_to_ws_valid}, 70'd0);
      chk("rst_ws_bus",   ms_to_ws_bus,            70'd0);
      chk("rst_ds_bus",   {32'd0, ms_to_ds_bus},   70'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // ALU passthrough
      send(32'h1c000000, 1'b1, 5'd5, 32'h12345678, 1'b0, 5'b00000, 32'h0);
      es_to_ms_valid = 1'b0;
      @(negedge clk);
      chk("alu_ws_valid", {69'd0, ms_to_ws_valid}, 70'd1);
      chk("alu_ds_bus", {32'd0, ms_to_ds_bus}, {32'd0, 1'b1, 5'd5, 32'h12345678});
      cycles(1);

      // Load alignment cases, back to back
      send(32'h1c000004, 1'b1, 5'd7,  32'h00001003, 1'b1, 5'b00001, 32'h80FF0011);
      send(32'h1c000008, 1'b1, 5'd8,  32'h00001003, 1'b1, 5'b00010, 32'h80FF0011);
      send(32'h1c00000c, 1'b1, 5'd9,  32'h00001002, 1'b1, 5'b00100, 32'h9abc1234);
      send(32'h1c000010, 1'b1, 5'd10, 32'h00001000, 1'b1, 5'b01000, 32'h9abc1234);
      send(32'h1c000014, 1'b1, 5'd11, 32'h00001000, 1'b1, 5'b10000, 32'h9abc1234);
      send(32'h1c000018, 1'b1, 5'd12, 32'h00001001, 1'b1, 5'b00000, 32'h76543210);
      es_to_ms_valid = 1'b0;
      cycles(2);

      // Stall: load must keep its captured data while SRAM output changes
      ws_allow_in = 1'b0;
      send(32'h1c000020, 1'b1, 5'd3, 32'h00002000, 1'b1, 5'b10000, 32'hA5A5A5A5);
      es_to_ms_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_result",   {38'd0, ms_to_ws_bus[69:38]}, {38'd0, 32'hA5A5A5A5});
         chk("stall_allow_in", {69'd0, ms_allow_in}, 70'd0);
         chk("stall_pc",       {38'd0, ms_to_ws_bus[31:0]}, {38'd0, 32'h1c000020});
         cycles(1);
      end
      ws_allow_in = 1'b1;
      cycles(2);

      // Four consecutive loads, each with distinct data and offset
      for (int i = 0; i < 4; i++)
         send(32'h1c000100 + 32'(4 * i), 1'b1, 5'(i + 1), 32'h00003000 + 32'(i),
              1'b1, 5'(1 << i), $urandom);
      es_to_ms_valid = 1'b0;
      cycles(2);

      // Random back-pressure during a burst
      fork
         begin
            for (int i = 0; i < 12; i++)
               send(32'h1c000200 + 32'(4 * i), 1'(i & 1), 5'(i + 16),
                    $urandom, 1'(i % 3 != 0), 5'(1 << (i % 5)), $urandom);
            es_to_ms_valid = 1'b0;
            burst_done = 1'b1;
         end
         begin
            while (!burst_done) begin
               @(posedge clk); #1;
               ws_allow_in = 1'($urandom_range(0, 1));
            end
            ws_allow_in = 1'b1;
         end
      join
      cycles(4);

      // Reset during a stall discards the held instruction
      ws_allow_in = 1'b0;
      send(32'h1c000300, 1'b1, 5'd20, 32'h00004000, 1'b1, 5'b10000, 32'h13579BDF);
      es_to_ms_valid = 1'b0;
      cycles(2);
      reset = 1'b1;
      cycles(1);
      reset = 1'b0;
      sb.delete();
      @(negedge clk);
      chk("rstmid_ws_valid", {69'd0, ms_to_ws_valid},   70'd0);
      chk("rstmid_ds_we",    {69'd0, ms_to_ds_bus[37]}, 70'd0);
      chk("rstmid_allow_in", {69'd0, ms_allow_in},      70'd1);
      cycles(1);
      ws_allow_in = 1'b1;
      send(32'h1c000304, 1'b1, 5'd21, 32'h00004002, 1'b1, 5'b00100, 32'h0BADF00D);
      es_to_ms_valid = 1'b0;
      cycles(3);

      chk("sb_drained", 70'(sb.size()), 70'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
